// File: rtl/reg_file.sv
// General-purpose register file: one synchronous write port and two
// combinational read ports, with an optional hard-wired zero register and write bypass.
module reg_file #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int DEPTH = 32'sd1 << ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              wr_en_s;

  // Shared read rule for both ports; register 0 and reset both force zero.
  function automatic logic [DATA_W-1:0] read_port(
    input logic              rst_ok,
    input logic              wr_en,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [DATA_W-1:0] wr_data,
    input logic [ADDR_W-1:0] rd_addr,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] val;
    if (!rst_ok) begin
      val = '0;
    end else if (ZERO_REG && (rd_addr == '0)) begin
      val = '0;
    end else if (BYPASS && wr_en && (wr_addr == rd_addr)) begin
      val = wr_data;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // A write is effective only out of reset and not when aimed at a hard-wired zero register.
  always_comb begin
    wr_en_s = 1'b0;
    if (rst_n && we && !(ZERO_REG && (waddr == '0))) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Register array: async clear, single write per rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Combinational read ports.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    rdata_a = read_port(rst_n, wr_en_s, waddr, wdata, raddr_a, mem_r[raddr_a]);
    rdata_b = read_port(rst_n, wr_en_s, waddr, wdata, raddr_b, mem_r[raddr_b]);
  end

endmodule
